// File: rtl/hwpe_tcdm_slice_wrap_pkg.sv
// Shared types and constants for the HWPE TCDM/periph slice wrapper.
// The structs show the payload layout at the default 32-bit widths.
package hwpe_wrap_package;

  localparam int SKID_DEPTH = 2;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ID_WIDTH   = 16;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]   add;
    logic                        wen;
    logic [DEF_DATA_WIDTH/8-1:0] be;
    logic [DEF_DATA_WIDTH-1:0]   data;
  } tcdm_req_t;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]   add;
    logic                        wen;
    logic [DEF_DATA_WIDTH/8-1:0] be;
    logic [DEF_DATA_WIDTH-1:0]   data;
    logic [DEF_ID_WIDTH-1:0]     id;
  } periph_req_t;

endpackage

// File: rtl/hwpe_tcdm_slice_wrap_skid_buffer.sv
// Two-entry FIFO skid buffer; in_ready depends only on occupancy, so no
// combinational path exists from either handshake side to the other.
module hwpe_skid_buffer
  import hwpe_wrap_package::*;
#(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T           mem_reg [SKID_DEPTH];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic [1:0] count_next;
  logic       push;
  logic       pop;

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = mem_reg[rd_ptr_reg];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 2'd1;
    end else if (!push && pop) begin
      count_next = count_reg - 2'd1;
    end
  end

  // Entries are cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= in_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/hwpe_tcdm_slice_wrap.sv
// Boundary slice between an HWPE engine and the TCDM / peripheral bus:
// skid-buffered requests, registered responses, per-port outstanding limit.
module hwpe_tcdm_slice_wrap
  import hwpe_wrap_package::*;
#(
  parameter  int N_PORTS         = 3,
  parameter  int ADDR_WIDTH      = 32,
  parameter  int DATA_WIDTH      = 32,
  parameter  int ID_WIDTH        = 16,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int BE_WIDTH        = DATA_WIDTH / 8,
  localparam int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_PORTS-1:0]              s_tcdm_req,
  output logic [N_PORTS-1:0]              s_tcdm_gnt,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]   s_tcdm_add,
  input  logic [N_PORTS-1:0]              s_tcdm_wen,
  input  logic [N_PORTS*BE_WIDTH-1:0]     s_tcdm_be,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   s_tcdm_data,
  output logic [N_PORTS*DATA_WIDTH-1:0]   s_tcdm_r_data,
  output logic [N_PORTS-1:0]              s_tcdm_r_valid,
  output logic [N_PORTS-1:0]              m_tcdm_req,
  input  logic [N_PORTS-1:0]              m_tcdm_gnt,
  output logic [N_PORTS*ADDR_WIDTH-1:0]   m_tcdm_add,
  output logic [N_PORTS-1:0]              m_tcdm_wen,
  output logic [N_PORTS*BE_WIDTH-1:0]     m_tcdm_be,
  output logic [N_PORTS*DATA_WIDTH-1:0]   m_tcdm_data,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   m_tcdm_r_data,
  input  logic [N_PORTS-1:0]              m_tcdm_r_valid,
  input  logic                            s_periph_req,
  output logic                            s_periph_gnt,
  input  logic [ADDR_WIDTH-1:0]           s_periph_add,
  input  logic                            s_periph_wen,
  input  logic [BE_WIDTH-1:0]             s_periph_be,
  input  logic [DATA_WIDTH-1:0]           s_periph_data,
  input  logic [ID_WIDTH-1:0]             s_periph_id,
  output logic [DATA_WIDTH-1:0]           s_periph_r_data,
  output logic                            s_periph_r_valid,
  output logic [ID_WIDTH-1:0]             s_periph_r_id,
  output logic                            m_periph_req,
  input  logic                            m_periph_gnt,
  output logic [ADDR_WIDTH-1:0]           m_periph_add,
  output logic                            m_periph_wen,
  output logic [BE_WIDTH-1:0]             m_periph_be,
  output logic [DATA_WIDTH-1:0]           m_periph_data,
  output logic [ID_WIDTH-1:0]             m_periph_id,
  input  logic [DATA_WIDTH-1:0]           m_periph_r_data,
  input  logic                            m_periph_r_valid,
  input  logic [ID_WIDTH-1:0]             m_periph_r_id,
  output logic [N_PORTS*CNT_WIDTH-1:0]    outstanding,
  output logic [N_PORTS-1:0]              proto_err
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] data;
  } tcdm_slot_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } periph_slot_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_tcdm
      tcdm_slot_t            in_slot;
      tcdm_slot_t            out_slot;
      logic                  buf_valid;
      logic                  cnt_ok;
      logic                  granted;
      logic                  r_valid_in;
      logic [CNT_WIDTH-1:0]  cnt_reg;
      logic                  err_reg;
      logic                  r_valid_reg;
      logic [DATA_WIDTH-1:0] r_data_reg;

      assign in_slot.add  = s_tcdm_add[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign in_slot.wen  = s_tcdm_wen[gi];
      assign in_slot.be   = s_tcdm_be[gi*BE_WIDTH +: BE_WIDTH];
      assign in_slot.data = s_tcdm_data[gi*DATA_WIDTH +: DATA_WIDTH];

      // Throttling gates both m_req and the pop, so a held head is never lost.
      assign cnt_ok     = (cnt_reg < CNT_MAX);
      assign granted    = m_tcdm_req[gi] & m_tcdm_gnt[gi];
      assign r_valid_in = m_tcdm_r_valid[gi];

      hwpe_skid_buffer #(.T(tcdm_slot_t)) i_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_tcdm_req[gi]),
        .in_ready  (s_tcdm_gnt[gi]),
        .in_data   (in_slot),
        .out_valid (buf_valid),
        .out_ready (m_tcdm_gnt[gi] & cnt_ok),
        .out_data  (out_slot)
      );

      assign m_tcdm_req[gi]                              = buf_valid & cnt_ok;
      assign m_tcdm_add[gi*ADDR_WIDTH +: ADDR_WIDTH]     = out_slot.add;
      assign m_tcdm_wen[gi]                              = out_slot.wen;
      assign m_tcdm_be[gi*BE_WIDTH +: BE_WIDTH]          = out_slot.be;
      assign m_tcdm_data[gi*DATA_WIDTH +: DATA_WIDTH]    = out_slot.data;

      // A response with nothing outstanding is flagged but still forwarded.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg     <= '0;
          err_reg     <= 1'b0;
          r_valid_reg <= 1'b0;
          r_data_reg  <= '0;
        end else begin
          if (granted && !r_valid_in) begin
            cnt_reg <= cnt_reg + CNT_WIDTH'(1);
          end else if (!granted && r_valid_in && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CNT_WIDTH'(1);
          end
          if (r_valid_in && (cnt_reg == '0)) begin
            err_reg <= 1'b1;
          end
          r_valid_reg <= r_valid_in;
          if (r_valid_in) begin
            r_data_reg <= m_tcdm_r_data[gi*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end

      assign outstanding[gi*CNT_WIDTH +: CNT_WIDTH]    = cnt_reg;
      assign proto_err[gi]                             = err_reg;
      assign s_tcdm_r_valid[gi]                        = r_valid_reg;
      assign s_tcdm_r_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_data_reg;
    end
  endgenerate

  periph_slot_t          p_in_slot;
  periph_slot_t          p_out_slot;
  logic                  p_r_valid_reg;
  logic [DATA_WIDTH-1:0] p_r_data_reg;
  logic [ID_WIDTH-1:0]   p_r_id_reg;

  assign p_in_slot.add  = s_periph_add;
  assign p_in_slot.wen  = s_periph_wen;
  assign p_in_slot.be   = s_periph_be;
  assign p_in_slot.data = s_periph_data;
  assign p_in_slot.id   = s_periph_id;

  hwpe_skid_buffer #(.T(periph_slot_t)) i_periph_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_periph_req),
    .in_ready  (s_periph_gnt),
    .in_data   (p_in_slot),
    .out_valid (m_periph_req),
    .out_ready (m_periph_gnt),
    .out_data  (p_out_slot)
  );

  assign m_periph_add  = p_out_slot.add;
  assign m_periph_wen  = p_out_slot.wen;
  assign m_periph_be   = p_out_slot.be;
  assign m_periph_data = p_out_slot.data;
  assign m_periph_id   = p_out_slot.id;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_r_valid_reg <= 1'b0;
      p_r_data_reg  <= '0;
      p_r_id_reg    <= '0;
    end else begin
      p_r_valid_reg <= m_periph_r_valid;
      if (m_periph_r_valid) begin
        p_r_data_reg <= m_periph_r_data;
        p_r_id_reg   <= m_periph_r_id;
      end
    end
  end

  assign s_periph_r_valid = p_r_valid_reg;
  assign s_periph_r_data  = p_r_data_reg;
  assign s_periph_r_id    = p_r_id_reg;

endmodule

// File: tb/tb_hwpe_tcdm_slice_wrap.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a queue-based transaction model of the wrapper.
module tb_hwpe_tcdm_slice_wrap;

  localparam int N    = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int IW   = 16;
  localparam int MAXO = 4;
  localparam int CW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    s_tcdm_req = '0, s_tcdm_gnt, s_tcdm_wen = '0, s_tcdm_r_valid;
  logic [N*AW-1:0] s_tcdm_add = '0;
  logic [N*BW-1:0] s_tcdm_be = '0;
  logic [N*DW-1:0] s_tcdm_data = '0, s_tcdm_r_data;
  logic [N-1:0]    m_tcdm_req, m_tcdm_gnt = '0, m_tcdm_wen, m_tcdm_r_valid = '0;
  logic [N*AW-1:0] m_tcdm_add;
  logic [N*BW-1:0] m_tcdm_be;
  logic [N*DW-1:0] m_tcdm_data, m_tcdm_r_data = '0;
  logic            s_periph_req = 1'b0, s_periph_gnt, s_periph_wen = 1'b0;
  logic [AW-1:0]   s_periph_add = '0;
  logic [BW-1:0]   s_periph_be = '0;
  logic [DW-1:0]   s_periph_data = '0, s_periph_r_data;
  logic [IW-1:0]   s_periph_id = '0, s_periph_r_id;
  logic            s_periph_r_valid;
  logic            m_periph_req, m_periph_gnt = 1'b0, m_periph_wen, m_periph_r_valid = 1'b0;
  logic [AW-1:0]   m_periph_add;
  logic [BW-1:0]   m_periph_be;
  logic [DW-1:0]   m_periph_data, m_periph_r_data = '0;
  logic [IW-1:0]   m_periph_id, m_periph_r_id = '0;
  logic [N*CW-1:0] outstanding;
  logic [N-1:0]    proto_err;

  hwpe_tcdm_slice_wrap #(
    .N_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .s_tcdm_req(s_tcdm_req), .s_tcdm_gnt(s_tcdm_gnt), .s_tcdm_add(s_tcdm_add),
    .s_tcdm_wen(s_tcdm_wen), .s_tcdm_be(s_tcdm_be), .s_tcdm_data(s_tcdm_data),
    .s_tcdm_r_data(s_tcdm_r_data), .s_tcdm_r_valid(s_tcdm_r_valid),
    .m_tcdm_req(m_tcdm_req), .m_tcdm_gnt(m_tcdm_gnt), .m_tcdm_add(m_tcdm_add),
    .m_tcdm_wen(m_tcdm_wen), .m_tcdm_be(m_tcdm_be), .m_tcdm_data(m_tcdm_data),
    .m_tcdm_r_data(m_tcdm_r_data), .m_tcdm_r_valid(m_tcdm_r_valid),
    .s_periph_req(s_periph_req), .s_periph_gnt(s_periph_gnt), .s_periph_add(s_periph_add),
    .s_periph_wen(s_periph_wen), .s_periph_be(s_periph_be), .s_periph_data(s_periph_data),
    .s_periph_id(s_periph_id), .s_periph_r_data(s_periph_r_data),
    .s_periph_r_valid(s_periph_r_valid), .s_periph_r_id(s_periph_r_id),
    .m_periph_req(m_periph_req), .m_periph_gnt(m_periph_gnt), .m_periph_add(m_periph_add),
    .m_periph_wen(m_periph_wen), .m_periph_be(m_periph_be), .m_periph_data(m_periph_data),
    .m_periph_id(m_periph_id), .m_periph_r_data(m_periph_r_data),
    .m_periph_r_valid(m_periph_r_valid), .m_periph_r_id(m_periph_r_id),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  typedef struct {
    logic [AW-1:0] add;
    logic          wen;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } req_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } resp_t;

  // Model: pending requests per buffer, memory-side pending responses.
  req_t          mq [N][$];
  resp_t         pend [N][$];
  int            os [N];
  bit            perr [N];
  bit            rv_exp [N];
  logic [DW-1:0] rd_exp [N];
  req_t          pq [$];
  resp_t         ppend [$];
  bit            prv_exp;
  logic [DW-1:0] prd_exp;
  logic [IW-1:0] pid_exp;

  // Stimulus knobs.
  int            req_pct [N], gnt_pct [N], resp_pct [N];
  bit            spur [N];
  logic [DW-1:0] spur_data [N];
  logic [AW-1:0] nxt_add [N];
  bit            force_read;
  int            p_req_pct, p_gnt_pct, p_resp_pct;
  bit            p_wen_rand;
  logic          p_wen_v;
  logic [IW-1:0] p_id_v;
  logic [AW-1:0] p_nxt_add;
  int            rv_cnt [N];
  int            pid_cnt;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      mq[p].delete();
      pend[p].delete();
      os[p] = 0;
      perr[p] = 1'b0;
      rv_exp[p] = 1'b0;
      rd_exp[p] = '0;
    end
    pq.delete();
    ppend.delete();
    prv_exp = 1'b0;
    prd_exp = '0;
    pid_exp = '0;
  endtask

  task automatic tick();
    bit   exp_gnt [N], exp_req [N];
    bit   pexp_gnt, pexp_req;
    req_t r;
    // Drive inputs for this cycle.
    for (int p = 0; p < N; p++) begin
      s_tcdm_req[p]             = ($urandom_range(99) < req_pct[p]);
      s_tcdm_add[p*AW +: AW]    = nxt_add[p];
      s_tcdm_wen[p]             = force_read ? 1'b1 : 1'($urandom);
      s_tcdm_be[p*BW +: BW]     = BW'($urandom);
      s_tcdm_data[p*DW +: DW]   = $urandom;
      m_tcdm_gnt[p]             = ($urandom_range(99) < gnt_pct[p]);
      if (spur[p]) begin
        m_tcdm_r_valid[p]        = 1'b1;
        spur_data[p]             = $urandom;
        m_tcdm_r_data[p*DW +: DW] = spur_data[p];
      end else if (pend[p].size() > 0 && $urandom_range(99) < resp_pct[p]) begin
        m_tcdm_r_valid[p]        = 1'b1;
        m_tcdm_r_data[p*DW +: DW] = pend[p][0].data;
      end else begin
        m_tcdm_r_valid[p]        = 1'b0;
        m_tcdm_r_data[p*DW +: DW] = $urandom;
      end
    end
    s_periph_req  = ($urandom_range(99) < p_req_pct);
    s_periph_add  = p_nxt_add;
    s_periph_wen  = p_wen_rand ? 1'($urandom) : p_wen_v;
    s_periph_be   = BW'($urandom);
    s_periph_data = $urandom;
    s_periph_id   = p_id_v;
    m_periph_gnt  = ($urandom_range(99) < p_gnt_pct);
    if (ppend.size() > 0 && $urandom_range(99) < p_resp_pct) begin
      m_periph_r_valid = 1'b1;
      m_periph_r_data  = ppend[0].data;
      m_periph_r_id    = ppend[0].id;
    end else begin
      m_periph_r_valid = 1'b0;
      m_periph_r_data  = $urandom;
      m_periph_r_id    = IW'($urandom);
    end
    #1;
    // Compare DUT outputs with the model.
    for (int p = 0; p < N; p++) begin
      exp_gnt[p] = (mq[p].size() < 2);
      exp_req[p] = (mq[p].size() > 0) && (os[p] < MAXO);
      check($sformatf("s_gnt[%0d]", p), s_tcdm_gnt[p], exp_gnt[p]);
      check($sformatf("m_req[%0d]", p), m_tcdm_req[p], exp_req[p]);
      if (mq[p].size() > 0) begin
        check($sformatf("m_add[%0d]", p), m_tcdm_add[p*AW +: AW], mq[p][0].add);
        check($sformatf("m_wen[%0d]", p), m_tcdm_wen[p], mq[p][0].wen);
        check($sformatf("m_be[%0d]", p), m_tcdm_be[p*BW +: BW], mq[p][0].be);
        check($sformatf("m_data[%0d]", p), m_tcdm_data[p*DW +: DW], mq[p][0].data);
      end
      check($sformatf("outstanding[%0d]", p), outstanding[p*CW +: CW], os[p]);
      check($sformatf("proto_err[%0d]", p), proto_err[p], perr[p]);
      check($sformatf("s_r_valid[%0d]", p), s_tcdm_r_valid[p], rv_exp[p]);
      check($sformatf("s_r_data[%0d]", p), s_tcdm_r_data[p*DW +: DW], rd_exp[p]);
      rv_cnt[p] += int'(s_tcdm_r_valid[p]);
    end
    pexp_gnt = (pq.size() < 2);
    pexp_req = (pq.size() > 0);
    check("p_s_gnt", s_periph_gnt, pexp_gnt);
    check("p_m_req", m_periph_req, pexp_req);
    if (pq.size() > 0) begin
      check("p_m_add", m_periph_add, pq[0].add);
      check("p_m_wen", m_periph_wen, pq[0].wen);
      check("p_m_data", m_periph_data, pq[0].data);
      check("p_m_id", m_periph_id, pq[0].id);
    end
    check("p_r_valid", s_periph_r_valid, prv_exp);
    check("p_r_data", s_periph_r_data, prd_exp);
    check("p_r_id", s_periph_r_id, pid_exp);
    if (s_periph_r_valid && s_periph_r_id == 16'h00A5) pid_cnt++;
    // Advance the model by one clock edge.
    for (int p = 0; p < N; p++) begin
      bit pop_h, push_h, rv;
      pop_h  = exp_req[p] && m_tcdm_gnt[p];
      push_h = s_tcdm_req[p] && exp_gnt[p];
      rv     = m_tcdm_r_valid[p];
      if (pop_h) begin
        pend[p].push_back('{data: mq[p][0].add ^ 32'hD00D_0000, id: '0});
        void'(mq[p].pop_front());
      end
      if (rv && !spur[p]) void'(pend[p].pop_front());
      if (rv && os[p] == 0) perr[p] = 1'b1;
      if (pop_h && !rv) os[p]++;
      else if (!pop_h && rv && os[p] > 0) os[p]--;
      rv_exp[p] = rv;
      if (rv) rd_exp[p] = m_tcdm_r_data[p*DW +: DW];
      if (push_h) begin
        r.add  = s_tcdm_add[p*AW +: AW];
        r.wen  = s_tcdm_wen[p];
        r.be   = s_tcdm_be[p*BW +: BW];
        r.data = s_tcdm_data[p*DW +: DW];
        r.id   = '0;
        mq[p].push_back(r);
        nxt_add[p] += 4;
      end
      spur[p] = 1'b0;
    end
    if (pexp_req && m_periph_gnt) begin
      ppend.push_back('{data: pq[0].add ^ 32'h0BAD_0000, id: pq[0].id});
      void'(pq.pop_front());
    end
    if (m_periph_r_valid) void'(ppend.pop_front());
    prv_exp = m_periph_r_valid;
    if (m_periph_r_valid) begin
      prd_exp = m_periph_r_data;
      pid_exp = m_periph_r_id;
    end
    if (s_periph_req && pexp_gnt) begin
      pq.push_back('{add: s_periph_add, wen: s_periph_wen, be: s_periph_be,
                     data: s_periph_data, id: s_periph_id});
      p_nxt_add += 4;
    end
    if (rst) model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_s_gnt", s_tcdm_gnt, {N{1'b1}});
    check("rst_m_req", m_tcdm_req, '0);
    check("rst_m_add", m_tcdm_add, '0);
    check("rst_m_wen", m_tcdm_wen, '0);
    check("rst_m_be", m_tcdm_be, '0);
    check("rst_m_data", m_tcdm_data, '0);
    check("rst_r_valid", s_tcdm_r_valid, '0);
    check("rst_r_data", s_tcdm_r_data, '0);
    check("rst_outstanding", outstanding, '0);
    check("rst_proto_err", proto_err, '0);
    check("rst_p_gnt", s_periph_gnt, 1'b1);
    check("rst_p_m_req", m_periph_req, 1'b0);
    check("rst_p_m_payload", {m_periph_add, m_periph_wen, m_periph_be, m_periph_data, m_periph_id}, '0);
    check("rst_p_r", {s_periph_r_valid, s_periph_r_data, s_periph_r_id}, '0);
  endtask

  task automatic all_idle();
    for (int p = 0; p < N; p++) begin
      req_pct[p] = 0; gnt_pct[p] = 100; resp_pct[p] = 100; spur[p] = 1'b0;
    end
    p_req_pct = 0; p_gnt_pct = 100; p_resp_pct = 100;
  endtask

  initial begin
    model_reset();
    all_idle();
    for (int p = 0; p < N; p++) begin
      nxt_add[p] = 32'h1000 * (p + 1);
      rv_cnt[p] = 0;
    end
    force_read = 1'b0;
    p_wen_rand = 1'b1; p_wen_v = 1'b0; p_id_v = '0; p_nxt_add = 32'h4000;
    pid_cnt = 0;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs();

    // Back-to-back reads on port 0, memory answering one cycle after grant.
    force_read = 1'b1;
    nxt_add[0] = 32'h100;
    rv_cnt[0] = 0;
    req_pct[0] = 100;
    for (int i = 0; i < 8; i++) tick();
    req_pct[0] = 0;
    for (int i = 0; i < 5; i++) tick();
    check("b2b_resp_count", rv_cnt[0], 8);
    check("b2b_next_add", nxt_add[0], 32'h120);
    force_read = 1'b0;

    // Stall port 1: only two requests fit before s_gnt drops.
    nxt_add[1] = 32'h200;
    req_pct[1] = 100; gnt_pct[1] = 0;
    for (int i = 0; i < 5; i++) tick();
    check("stall_s_gnt", s_tcdm_gnt[1], 1'b0);
    check("stall_m_add", m_tcdm_add[AW +: AW], 32'h200);
    req_pct[1] = 0; gnt_pct[1] = 100;
    for (int i = 0; i < 6; i++) tick();

    // Throttle port 2 at MAX_OUTSTANDING with responses withheld.
    req_pct[2] = 100; resp_pct[2] = 0;
    for (int i = 0; i < 8; i++) tick();
    check("thr_outstanding", outstanding[2*CW +: CW], 3'd4);
    check("thr_m_req_low", m_tcdm_req[2], 1'b0);
    req_pct[2] = 0; resp_pct[2] = 100;
    tick();
    check("thr_after_resp", outstanding[2*CW +: CW], 3'd3);
    check("thr_m_req_high", m_tcdm_req[2], 1'b1);
    for (int i = 0; i < 12; i++) tick();

    // Grant and response in the same cycle at outstanding=2.
    req_pct[0] = 100; resp_pct[0] = 0;
    for (int i = 0; i < 3; i++) tick();
    check("sim_pre", outstanding[0 +: CW], 3'd2);
    req_pct[0] = 0; resp_pct[0] = 100;
    tick();
    check("sim_hold", outstanding[0 +: CW], 3'd2);
    for (int i = 0; i < 6; i++) tick();

    // Spurious response on idle port 1.
    spur[1] = 1'b1;
    tick();
    check("spur_proto_err", proto_err[1], 1'b1);
    check("spur_outstanding", outstanding[CW +: CW], 3'd0);
    check("spur_fwd_valid", s_tcdm_r_valid[1], 1'b1);
    check("spur_fwd_data", s_tcdm_r_data[DW +: DW], spur_data[1]);

    // Periph write then read with id 0x00A5.
    p_wen_rand = 1'b0; p_id_v = 16'h00A5; pid_cnt = 0;
    p_req_pct = 100; p_wen_v = 1'b0;
    tick();
    p_wen_v = 1'b1;
    tick();
    p_req_pct = 0;
    for (int i = 0; i < 5; i++) tick();
    check("periph_id_resp", pid_cnt, 2);
    p_wen_rand = 1'b1;

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) begin
        for (int p = 0; p < N; p++) begin
          req_pct[p]  = $urandom_range(100);
          gnt_pct[p]  = $urandom_range(100);
          resp_pct[p] = $urandom_range(100);
        end
        p_req_pct = $urandom_range(100);
        p_gnt_pct = $urandom_range(100);
        p_resp_pct = $urandom_range(100);
        p_id_v = IW'($urandom);
      end
      if (i == 200) rst = 1'b1;
      tick();
      if (i == 201) begin
        rst = 1'b0;
        check_reset_outputs();
      end
    end

    all_idle();
    for (int i = 0; i < 20; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
